axis_pkt_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one AXI-Stream NoC injection port between NUM_SRC traffic sources (the num_gen generators or any AXI-Stream master). It locks a grant from the first beat of a packet until the TLAST handshake, so packets never interleave. It stamps the source index into TID and keeps per-source packet counts. It sits between the generators and the router's local input port.

---
 rtl/noc_arb_pkg.sv | 29 ++
 rtl/rr_pick.sv | 34 +++
 rtl/axis_pkt_arbiter.sv | 118 +++++++++++
 tb/tb_axis_pkt_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
// noc_arb_pkg: shared types and helpers for the AXI-Stream packet arbiter.
//   arb_state_t : arbiter FSM state (idle / packet locked)
//   src_w()     : index width for a given number of sources (never below 1)
//   get_slice() : extracts element idx of width w from a flat vector
package noc_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_LOCK
    } arb_state_t;

    // Upper bounds for get_slice(); flat inputs wider than MAX_FLAT are truncated.
    localparam int unsigned MAX_FLAT  = 512;
    localparam int unsigned MAX_SLICE = 64;

    function automatic int unsigned src_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // The caller truncates the result to its own element width.
    function automatic logic [MAX_SLICE-1:0] get_slice(input logic [MAX_FLAT-1:0] vec,
                                                       input int unsigned         idx,
                                                       input int unsigned         w);
        logic [MAX_FLAT-1:0] sh;
        sh = vec >> (idx * w);
        return sh[MAX_SLICE-1:0];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req   : request vector, one bit per source
//   ptr   : highest-priority source index for this pick
//   valid : at least one request is set
//   idx   : first requesting source at or after ptr, wrapping modulo NUM_SRC
module rr_pick #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SRCW    = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRCW-1:0]    ptr,
    output logic               valid,
    output logic [SRCW-1:0]    idx
);

    always_comb begin
        int unsigned c;
        c     = 0;
        valid = 1'b0;
        idx   = '0;
        // Walk from the farthest offset down so the nearest requester wins.
        for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
            c = 32'(ptr) + 32'(k);
            if (c >= NUM_SRC) begin
                c = c - NUM_SRC;
            end
            if (|(req & (NUM_SRC'(1) << c))) begin
                valid = 1'b1;
                idx   = SRCW'(c);
            end
        end
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-granular round-robin arbiter sharing one AXI-Stream
// master port between NUM_SRC sources. A grant is locked from the first beat
// until the TLAST handshake, so packets never interleave.
//   CLK, RST_N        : clock, asynchronous active-low reset
//   S_T* (flat)       : per-source slave ports, source i at slice i
//   M_T*              : shared master port; M_TID carries the granted source index
//   GRANT_ID          : current grant, or the last one while idle
//   BUSY              : high while a packet is locked
//   STAT_PKTS (flat)  : completed packets per source, wrapping counters
module axis_pkt_arbiter
    import noc_arb_pkg::*;
#(
    parameter int unsigned TDATAW  = 32,
    parameter int unsigned TDESTW  = 4,
    parameter int unsigned TIDW    = 2,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned CNTW    = 16
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [NUM_SRC-1:0]          S_TVALID,
    output logic [NUM_SRC-1:0]          S_TREADY,
    input  logic [NUM_SRC*TDATAW-1:0]   S_TDATA,
    input  logic [NUM_SRC-1:0]          S_TLAST,
    input  logic [NUM_SRC*TDESTW-1:0]   S_TDEST,
    output logic                        M_TVALID,
    input  logic                        M_TREADY,
    output logic [TDATAW-1:0]           M_TDATA,
    output logic                        M_TLAST,
    output logic [TIDW-1:0]             M_TID,
    output logic [TDESTW-1:0]           M_TDEST,
    output logic [src_w(NUM_SRC)-1:0]   GRANT_ID,
    output logic                        BUSY,
    output logic [NUM_SRC*CNTW-1:0]     STAT_PKTS
);

    localparam int unsigned SRCW = src_w(NUM_SRC);

    arb_state_t                     state_q, state_d;
    logic [SRCW-1:0]                grant_q;
    logic [SRCW-1:0]                ptr_q;
    logic [NUM_SRC-1:0][CNTW-1:0]   cnt_q;
    logic                           pick_valid;
    logic [SRCW-1:0]                pick_idx;
    logic                           pkt_done;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SRCW    (SRCW)
    ) u_pick (
        .req   (S_TVALID),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: if (pick_valid) state_d = ARB_LOCK;
            ARB_LOCK: if (pkt_done)   state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Output logic: the granted slice is wired straight through while locked.
    always_comb begin
        M_TVALID = 1'b0;
        M_TLAST  = 1'b0;
        M_TDATA  = '0;
        M_TDEST  = '0;
        M_TID    = '0;
        S_TREADY = '0;
        if (state_q == ARB_LOCK) begin
            M_TVALID          = S_TVALID[grant_q];
            M_TLAST           = S_TLAST[grant_q];
            M_TDATA           = TDATAW'(get_slice(MAX_FLAT'(S_TDATA), 32'(grant_q), TDATAW));
            M_TDEST           = TDESTW'(get_slice(MAX_FLAT'(S_TDEST), 32'(grant_q), TDESTW));
            M_TID             = TIDW'(grant_q);
            S_TREADY[grant_q] = M_TREADY;
        end
    end

    // M_TVALID is already gated by the lock state.
    assign pkt_done = M_TVALID & M_TREADY & M_TLAST;

    // Grant, round-robin pointer and packet counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (state_q == ARB_IDLE && pick_valid) begin
                grant_q <= pick_idx;
            end
            if (pkt_done) begin
                ptr_q          <= (grant_q == SRCW'(NUM_SRC - 1)) ? '0 : grant_q + SRCW'(1);
                cnt_q[grant_q] <= cnt_q[grant_q] + CNTW'(1);
            end
        end
    end

    assign GRANT_ID  = grant_q;
    assign BUSY      = (state_q == ARB_LOCK);
    assign STAT_PKTS = cnt_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Testbench for axis_pkt_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_axis_pkt_arbiter;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DESTW = 4;
    localparam int TIDW  = 2;
    localparam int CNTW  = 4;
    localparam int SW    = 2;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic [N-1:0]      S_TVALID, S_TREADY, S_TLAST;
    logic [N*DW-1:0]   S_TDATA;
    logic [N*DESTW-1:0] S_TDEST;
    logic              M_TVALID, M_TREADY, M_TLAST;
    logic [DW-1:0]     M_TDATA;
    logic [TIDW-1:0]   M_TID;
    logic [DESTW-1:0]  M_TDEST;
    logic [SW-1:0]     GRANT_ID;
    logic              BUSY;
    logic [N*CNTW-1:0] STAT_PKTS;

    always #5 CLK = ~CLK;

    axis_pkt_arbiter #(
        .TDATAW  (DW),
        .TDESTW  (DESTW),
        .TIDW    (TIDW),
        .NUM_SRC (N),
        .CNTW    (CNTW)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .S_TVALID  (S_TVALID),
        .S_TREADY  (S_TREADY),
        .S_TDATA   (S_TDATA),
        .S_TLAST   (S_TLAST),
        .S_TDEST   (S_TDEST),
        .M_TVALID  (M_TVALID),
        .M_TREADY  (M_TREADY),
        .M_TDATA   (M_TDATA),
        .M_TLAST   (M_TLAST),
        .M_TID     (M_TID),
        .M_TDEST   (M_TDEST),
        .GRANT_ID  (GRANT_ID),
        .BUSY      (BUSY),
        .STAT_PKTS (STAT_PKTS)
    );

    // Source packet queues (beats not yet accepted).
    logic [DW-1:0]    q_data [N][$];
    logic             q_last [N][$];
    logic [DESTW-1:0] q_dest [N][$];
    logic [DW-1:0]    exp_src [N][$];

    // Delivered beats seen on the master port.
    int            del_tid [$];
    logic [DW-1:0] del_data [$];

    // Reference model of the arbiter.
    bit m_lock;
    int m_g, m_ptr;
    int m_cnt [N];

    int  vpct = 100;
    int  rmode = 0;
    bit  tog;
    int  busy_cnt, cyc_cnt;
    int  n_checks = 0;
    int  n_pass = 0;

    task automatic model_reset();
        m_lock = 0;
        m_g    = 0;
        m_ptr  = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            q_data[i].delete();
            q_last[i].delete();
            q_dest[i].delete();
            exp_src[i].delete();
        end
        del_tid.delete();
        del_data.delete();
    endtask

    task automatic drive_idle();
        S_TVALID = '0;
        S_TLAST  = '0;
        S_TDATA  = '0;
        S_TDEST  = '0;
        M_TREADY = 1'b0;
    endtask

    task automatic enq(input int s, input int beats, input logic [DW-1:0] base);
        for (int b = 0; b < beats; b++) begin
            q_data[s].push_back(base + DW'(b));
            q_last[s].push_back(b == beats - 1);
            q_dest[s].push_back(DESTW'($urandom));
            exp_src[s].push_back(base + DW'(b));
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (q_data[i].size() != 0) return 0;
        return 1;
    endfunction

    // One clock cycle: drive sources, compare DUT with the model, advance both.
    task automatic step();
        logic [N-1:0]      v;
        logic [39:0]       exp_m, act_m;
        logic [N-1:0]      exp_sr;
        logic [N*CNTW-1:0] exp_stat;
        logic [SW-1:0]     exp_gid;
        bit                exp_busy, hs, el;
        int                c;
        @(negedge CLK);
        for (int i = 0; i < N; i++) begin
            v[i] = (q_data[i].size() > 0) && ($urandom_range(0, 99) < vpct);
            S_TVALID[i]              = v[i];
            S_TDATA[i*DW +: DW]      = v[i] ? q_data[i][0] : DW'($urandom);
            S_TLAST[i]               = v[i] ? q_last[i][0] : 1'($urandom);
            S_TDEST[i*DESTW +: DESTW] = v[i] ? q_dest[i][0] : DESTW'($urandom);
        end
        case (rmode)
            1:       begin M_TREADY = tog; tog = ~tog; end
            2:       M_TREADY = 1'($urandom_range(0, 1));
            default: M_TREADY = 1'b1;
        endcase
        #1;
        if (m_lock) begin
            el       = S_TLAST[m_g];
            exp_m    = {v[m_g], el, S_TDATA[m_g*DW +: DW], TIDW'(m_g),
                        S_TDEST[m_g*DESTW +: DESTW]};
            exp_sr   = M_TREADY ? (N'(1) << m_g) : '0;
            exp_busy = 1'b1;
        end else begin
            el       = 1'b0;
            exp_m    = '0;
            exp_sr   = '0;
            exp_busy = 1'b0;
        end
        exp_gid = SW'(m_g);
        for (int i = 0; i < N; i++) exp_stat[i*CNTW +: CNTW] = CNTW'(m_cnt[i]);
        act_m = {M_TVALID, M_TLAST, M_TDATA, M_TID, M_TDEST};

        n_checks++;
        if (act_m !== exp_m) $display("FAIL master cyc%0d: got %h expected %h", cyc_cnt, act_m, exp_m);
        else n_pass++;
        n_checks++;
        if (S_TREADY !== exp_sr) $display("FAIL s_tready cyc%0d: got %b expected %b", cyc_cnt, S_TREADY, exp_sr);
        else n_pass++;
        n_checks++;
        if ({BUSY, GRANT_ID} !== {exp_busy, exp_gid})
            $display("FAIL busy_grant cyc%0d: got %b/%0d expected %b/%0d", cyc_cnt, BUSY, GRANT_ID, exp_busy, exp_gid);
        else n_pass++;
        n_checks++;
        if (STAT_PKTS !== exp_stat) $display("FAIL stat_pkts cyc%0d: got %h expected %h", cyc_cnt, STAT_PKTS, exp_stat);
        else n_pass++;

        if (BUSY) busy_cnt++;
        cyc_cnt++;
        if (M_TVALID && M_TREADY) begin
            del_tid.push_back(int'(M_TID));
            del_data.push_back(M_TDATA);
        end
        for (int i = 0; i < N; i++) begin
            if (S_TVALID[i] && S_TREADY[i] && q_data[i].size() > 0) begin
                void'(q_data[i].pop_front());
                void'(q_last[i].pop_front());
                void'(q_dest[i].pop_front());
            end
        end

        hs = m_lock && v[m_g] && M_TREADY;
        if (!m_lock) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!m_lock && v[c]) begin
                    m_lock = 1;
                    m_g    = c;
                end
            end
        end else if (hs && el) begin
            m_lock   = 0;
            m_ptr    = (m_g + 1) % N;
            m_cnt[m_g] = (m_cnt[m_g] + 1) % (1 << CNTW);
        end
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while (!(all_empty() && !m_lock)) begin
            if (n >= budget) begin
                n_checks++;
                $display("FAIL %s timeout: got %0d cycles expected < %0d", name, n, budget);
                return;
            end
            step();
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        drive_idle();
        clear_all();
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        drive_idle();
        model_reset();
        #2;
        n_checks++;
        if ({M_TVALID, M_TLAST, M_TDATA, M_TID, M_TDEST, S_TREADY, BUSY, GRANT_ID, STAT_PKTS} !== '0)
            $display("FAIL reset_values: got %b%b %h %0d %0d %b %b %0d %h expected all 0",
                     M_TVALID, M_TLAST, M_TDATA, M_TID, M_TDEST, S_TREADY, BUSY, GRANT_ID, STAT_PKTS);
        else n_pass++;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_single();
        logic [DW-1:0] want [3];
        want = '{32'h11, 32'h22, 32'h33};
        clear_all();
        busy_cnt = 0;
        for (int b = 0; b < 3; b++) begin
            q_data[0].push_back(want[b]);
            q_last[0].push_back(b == 2);
            q_dest[0].push_back(4'h5);
        end
        drain(20, "single");
        n_checks++;
        if (busy_cnt != 3) $display("FAIL single_busy: got %0d cycles expected 3", busy_cnt);
        else n_pass++;
        for (int b = 0; b < 3; b++) begin
            n_checks++;
            if (del_data.size() <= b || del_data[b] !== want[b] || del_tid[b] != 0)
                $display("FAIL single_beat%0d: got %h expected %h", b,
                         (del_data.size() > b) ? del_data[b] : 'x, want[b]);
            else n_pass++;
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if (STAT_PKTS[0 +: CNTW] !== CNTW'(1))
            $display("FAIL single_stat: got %0d expected 1", STAT_PKTS[0 +: CNTW]);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int want [6];
        want = '{0, 1, 3, 0, 1, 3};
        do_reset();
        enq(0, 1, 32'hA0); enq(0, 1, 32'hA1);
        enq(1, 1, 32'hB0); enq(1, 1, 32'hB1);
        enq(3, 1, 32'hD0); enq(3, 1, 32'hD1);
        cyc_cnt = 0;
        drain(40, "round_robin");
        n_checks++;
        if (cyc_cnt != 12) $display("FAIL rr_cycles: got %0d expected 12", cyc_cnt);
        else n_pass++;
        for (int j = 0; j < 6; j++) begin
            n_checks++;
            if (del_tid.size() <= j || del_tid[j] != want[j])
                $display("FAIL rr_order%0d: got %0d expected %0d", j,
                         (del_tid.size() > j) ? del_tid[j] : -1, want[j]);
            else n_pass++;
        end
    endtask

    task automatic test_no_interleave();
        int want [6];
        int n;
        want = '{2, 2, 2, 2, 1, 1};
        clear_all();
        enq(2, 4, 32'h200);
        n = 0;
        while (del_data.size() < 2 && n < 20) begin
            step();
            n++;
        end
        enq(1, 2, 32'h100);
        drain(40, "no_interleave");
        for (int j = 0; j < 6; j++) begin
            n_checks++;
            if (del_tid.size() <= j || del_tid[j] != want[j])
                $display("FAIL interleave%0d: got %0d expected %0d", j,
                         (del_tid.size() > j) ? del_tid[j] : -1, want[j]);
            else n_pass++;
        end
    endtask

    task automatic test_ready_toggle();
        clear_all();
        rmode = 1;
        tog   = 1'b1;
        enq(1, 4, 32'h300);
        drain(40, "ready_toggle");
        rmode = 0;
        n_checks++;
        if (del_data.size() != 4) $display("FAIL toggle_count: got %0d beats expected 4", del_data.size());
        else n_pass++;
        for (int b = 0; b < 4 && b < del_data.size(); b++) begin
            n_checks++;
            if (del_data[b] !== 32'h300 + DW'(b))
                $display("FAIL toggle_beat%0d: got %h expected %h", b, del_data[b], 32'h300 + DW'(b));
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        int n;
        clear_all();
        enq(3, 4, 32'h400);
        n = 0;
        while (del_data.size() < 1 && n < 20) begin
            step();
            n++;
        end
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        n_checks++;
        if ({M_TVALID, M_TLAST, M_TDATA, M_TID, M_TDEST, S_TREADY, BUSY, GRANT_ID, STAT_PKTS} !== '0)
            $display("FAIL async_reset: got %b%b %h %0d %0d %b %b %0d %h expected all 0",
                     M_TVALID, M_TLAST, M_TDATA, M_TID, M_TDEST, S_TREADY, BUSY, GRANT_ID, STAT_PKTS);
        else n_pass++;
        drive_idle();
        clear_all();
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        enq(2, 1, 32'h520);
        enq(0, 1, 32'h500);
        drain(20, "post_reset");
        n_checks++;
        if (del_tid.size() < 1 || del_tid[0] != 0)
            $display("FAIL post_reset_winner: got %0d expected 0", (del_tid.size() > 0) ? del_tid[0] : -1);
        else n_pass++;
        @(posedge CLK);
        #1;
        n_checks++;
        if (STAT_PKTS[3*CNTW +: CNTW] !== '0)
            $display("FAIL reset_stat3: got %0d expected 0", STAT_PKTS[3*CNTW +: CNTW]);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int p = 0; p < 17; p++) enq(0, 1, DW'(p));
        drain(100, "wrap");
        @(posedge CLK);
        #1;
        n_checks++;
        if (STAT_PKTS[0 +: CNTW] !== CNTW'(1))
            $display("FAIL wrap_stat0: got %0d expected 1", STAT_PKTS[0 +: CNTW]);
        else n_pass++;
    endtask

    task automatic test_random();
        int s;
        clear_all();
        vpct  = 70;
        rmode = 2;
        for (int p = 0; p < 40; p++) begin
            s = $urandom_range(0, N - 1);
            enq(s, $urandom_range(1, 4), {8'(s), 8'(p), 16'h0});
        end
        drain(3000, "random");
        vpct  = 100;
        rmode = 0;
        for (int j = 0; j < del_data.size(); j++) begin
            s = del_tid[j];
            n_checks++;
            if (exp_src[s].size() == 0) begin
                $display("FAIL random_beat%0d: got %h from src %0d expected none", j, del_data[j], s);
            end else begin
                if (del_data[j] !== exp_src[s][0])
                    $display("FAIL random_beat%0d: got %h expected %h", j, del_data[j], exp_src[s][0]);
                else n_pass++;
                void'(exp_src[s].pop_front());
            end
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (exp_src[i].size() != 0)
                $display("FAIL random_left%0d: got %0d undelivered beats expected 0", i, exp_src[i].size());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_no_interleave();
        test_ready_toggle();
        test_async_reset();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
